// File: rtl/clock_meter_pkg.sv
// Shared types and constants for the divided-clock ratio meter.
package clock_meter_pkg;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(255);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    // |2*hi - per| <= 1, evaluated in 9 bits so 2*hi cannot wrap
    function automatic logic duty_check(
        input logic [CNT_W-1:0] per,
        input logic [CNT_W-1:0] hi
    );
        logic [CNT_W:0] two_hi;
        logic [CNT_W:0] per9;
        two_hi = {hi, 1'b0};
        per9   = {1'b0, per};
        if (two_hi >= per9)
            return (two_hi - per9) <= (CNT_W+1)'(1);
        else
            return (per9 - two_hi) <= (CNT_W+1)'(1);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus delayed copy; reports synced level and edges.
module sync_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic dly;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            dly <= 1'b0;
        end else begin
            s1  <= din;
            s2  <= s1;
            dly <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~dly;
    assign fall  = ~s2 & dly;

endmodule

// File: rtl/clock_ratio_meter.sv
// Measures period/high time of a divided clock against clk.
// Optional lock detection enabled by CLOCK_RATIO_METER_LOCK_EN.
module clock_ratio_meter
    import clock_meter_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             div_clk_in,
    output logic [CNT_W-1:0] n_meas,
    output logic [CNT_W-1:0] high_meas,
    output logic             meas_valid,
    output logic             duty_ok,
    output logic             locked,
    output logic             overflow
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic             fall_seen;
    logic             level;
    logic             rise;
    logic             fall;

    sync_edge_detect u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (div_clk_in),
        .level   (level),
        .rise    (rise),
        .fall    (fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:    state_next = ARM;
                ARM:     if (rise) state_next = MEASURE;
                MEASURE: if (!rise && per_cnt == CNT_MAX) state_next = ARM;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            per_cnt    <= '0;
            hi_cnt     <= '0;
            fall_seen  <= 1'b0;
            n_meas     <= '0;
            high_meas  <= '0;
            meas_valid <= 1'b0;
            duty_ok    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!enable || state == IDLE) begin
                per_cnt   <= '0;
                hi_cnt    <= '0;
                fall_seen <= 1'b0;
            end else if (rise) begin
                // a rise always wins over saturation, so 255 is measurable
                if (state == MEASURE) begin
                    n_meas     <= per_cnt;
                    high_meas  <= hi_cnt;
                    duty_ok    <= duty_check(per_cnt, hi_cnt);
                    meas_valid <= 1'b1;
                    overflow   <= 1'b0;
                end
                per_cnt   <= CNT_W'(1);
                hi_cnt    <= CNT_W'(1);
                fall_seen <= 1'b0;
            end else if (state == MEASURE) begin
                if (per_cnt == CNT_MAX) begin
                    overflow <= 1'b1;
                end else begin
                    per_cnt <= per_cnt + CNT_W'(1);
                    if (level && !fall_seen)
                        hi_cnt <= hi_cnt + CNT_W'(1);
                    if (fall)
                        fall_seen <= 1'b1;
                end
            end
        end
    end

`ifdef CLOCK_RATIO_METER_LOCK_EN
    localparam logic [3:0] LOCK_MAX = 4'(LOCK_COUNT);

    logic [3:0] lock_cnt;
    logic       meas_event;
    logic       sat_event;

    assign meas_event = enable && state == MEASURE && rise;
    assign sat_event  = enable && state == MEASURE && !rise
                        && per_cnt == CNT_MAX;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_cnt <= 4'd0;
            locked   <= 1'b0;
        end else if (!enable || state == IDLE || sat_event) begin
            lock_cnt <= 4'd0;
            locked   <= 1'b0;
        end else if (meas_event) begin
            // n_meas still holds the previous period here
            if (per_cnt == n_meas) begin
                if (lock_cnt < LOCK_MAX) begin
                    lock_cnt <= lock_cnt + 4'd1;
                    locked   <= (lock_cnt + 4'd1) == LOCK_MAX;
                end else begin
                    locked <= 1'b1;
                end
            end else begin
                lock_cnt <= 4'd1;
                locked   <= 1'b0;
            end
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^4'(LOCK_COUNT);
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Directed self-checking bench for clock_ratio_meter.
module tb_clock_ratio_meter;

    import clock_meter_pkg::*;

`ifdef CLOCK_RATIO_METER_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic             clk;
    logic             reset_n;
    logic             enable;
    logic             div_clk_in;
    logic [CNT_W-1:0] n_meas;
    logic [CNT_W-1:0] high_meas;
    logic             meas_valid;
    logic             duty_ok;
    logic             locked;
    logic             overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int last_gap = 0;

    int next_n  = 0;
    int next_hi = 0;
    int cur_n   = 0;
    int cur_hi  = 0;
    int phase   = 0;

    clock_ratio_meter #(.LOCK_COUNT(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .div_clk_in (div_clk_in),
        .n_meas     (n_meas),
        .high_meas  (high_meas),
        .meas_valid (meas_valid),
        .duty_ok    (duty_ok),
        .locked     (locked),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // divided-clock source; new divisor takes effect only at a period boundary
    initial begin
        div_clk_in = 1'b0;
        forever begin
            @(negedge clk);
            if (phase == 0) begin
                cur_n  = next_n;
                cur_hi = next_hi;
            end
            if (cur_n == 0) begin
                div_clk_in = 1'b0;
                phase      = 0;
            end else begin
                div_clk_in = (phase < cur_hi);
                phase      = (phase + 1 >= cur_n) ? 0 : phase + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic next_mv(input string tag);
        int c;
        c = 0;
        do begin
            @(posedge clk);
            #1;
            c++;
        end while (!meas_valid && c < 400);
        last_gap = c;
        check({tag, "_seen"}, 32'(meas_valid), 1);
    endtask

    task automatic wait_n(input string tag, input int target);
        for (int i = 0; i < 6; i++) begin
            next_mv(tag);
            if (n_meas == CNT_W'(target)) break;
        end
        check({tag, "_n"}, 32'(n_meas), 32'(target));
    endtask

    task automatic set_div(input int n, input int hi);
        next_n  = n;
        next_hi = hi;
    endtask

    initial begin
        int c;
        int vcount;
        reset_n = 1'b0;
        enable  = 1'b0;
        set_div(0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_n_meas", 32'(n_meas), 0);
        check("rst_high", 32'(high_meas), 0);
        check("rst_valid", 32'(meas_valid), 0);
        check("rst_duty", 32'(duty_ok), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_ovf", 32'(overflow), 0);

        // n=4, 50% duty
        reset_n = 1'b1;
        enable  = 1'b1;
        set_div(4, 2);
        for (int k = 1; k <= 5; k++) begin
            next_mv("d4");
            check("d4_n", 32'(n_meas), 4);
            check("d4_hi", 32'(high_meas), 2);
            check("d4_duty", 32'(duty_ok), 1);
            check("d4_lock", 32'(locked), 32'(LOCK_EN && k >= 4));
            if (k > 1) check("d4_gap", 32'(last_gap), 4);
        end
        @(posedge clk);
        #1;
        check("d4_pulse", 32'(meas_valid), 0);

        // n=7, high 4
        set_div(7, 4);
        wait_n("d7", 7);
        check("d7_lock1", 32'(locked), 0);
        for (int k = 2; k <= 4; k++) begin
            next_mv("d7");
            check("d7_n", 32'(n_meas), 7);
            check("d7_hi", 32'(high_meas), 4);
            check("d7_duty", 32'(duty_ok), 1);
            check("d7_lock", 32'(locked), 32'(LOCK_EN && k >= 4));
        end

        // minimum period
        set_div(2, 1);
        wait_n("d2", 2);
        next_mv("d2");
        check("d2_gap", 32'(last_gap), 2);
        check("d2_hi", 32'(high_meas), 1);
        check("d2_duty", 32'(duty_ok), 1);

        // badly skewed duty
        set_div(9, 3);
        wait_n("d9", 9);
        check("d9_hi", 32'(high_meas), 3);
        check("d9_duty", 32'(duty_ok), 0);

        // lock at 6, then switch to 10
        set_div(6, 3);
        wait_n("d6", 6);
        for (int k = 2; k <= 4; k++) next_mv("d6");
        check("d6_lock", 32'(locked), 32'(LOCK_EN));
        set_div(10, 5);
        for (int i = 0; i < 6; i++) begin
            next_mv("d10");
            if (n_meas != CNT_W'(6)) break;
        end
        check("d10_first_n", 32'(n_meas), 10);
        check("d10_first_lock", 32'(locked), 0);
        check("d10_hi", 32'(high_meas), 5);
        for (int k = 2; k <= 4; k++) begin
            next_mv("d10");
            check("d10_lock", 32'(locked), 32'(LOCK_EN && k >= 4));
        end

        // stop the input: overflow 255 cycles after the last rise
        set_div(0, 0);
        c = 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            if (meas_valid) c = 0;
            else            c++;
            if (overflow) break;
        end
        check("ovf_set", 32'(overflow), 1);
        check("ovf_cycles", 32'(c), 255);
        check("ovf_lock", 32'(locked), 0);
        check("ovf_n_hold", 32'(n_meas), 10);
        repeat (10) @(posedge clk);
        #1;
        check("ovf_sticky", 32'(overflow), 1);

        // restart clears overflow on the next measurement
        set_div(5, 3);
        wait_n("d5", 5);
        check("d5_ovf", 32'(overflow), 0);
        check("d5_hi", 32'(high_meas), 3);
        check("d5_duty", 32'(duty_ok), 1);

        // asynchronous reset mid-period
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_n", 32'(n_meas), 0);
        check("ar_hi", 32'(high_meas), 0);
        check("ar_valid", 32'(meas_valid), 0);
        check("ar_duty", 32'(duty_ok), 0);
        check("ar_lock", 32'(locked), 0);
        check("ar_ovf", 32'(overflow), 0);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (!div_clk_in) break;
        end
        reset_n = 1'b1;
        c = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            c++;
            if (meas_valid) break;
        end
        check("rel_seen", 32'(meas_valid), 1);
        check("rel_not_early", 32'(c >= 8), 1);
        check("rel_n", 32'(n_meas), 5);

        // enable drop mid-period
        next_mv("en");
        repeat (2) @(posedge clk);
        #1;
        enable = 1'b0;
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (meas_valid) vcount++;
        end
        check("en_no_valid", 32'(vcount), 0);
        check("en_n_hold", 32'(n_meas), 5);
        check("en_hi_hold", 32'(high_meas), 3);
        check("en_duty_hold", 32'(duty_ok), 1);
        check("en_lock", 32'(locked), 0);
        check("en_ovf", 32'(overflow), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_ratio_meter.md
# clock_ratio_meter

Measures an incoming divided clock (as produced by the CPLD clock divider) against the system clock and reports the division ratio, high time and a lock indication. It sits on the receive side of any divided-clock link and lets the MCU-facing register logic check that a programmed divisor actually appears on the wire. The input is treated as asynchronous, so it is synchronized before any measurement.

## Interface
- `LOCK_COUNT`, default 4: consecutive identical periods required to assert `locked`; range 2..15.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  measurement enable; low forces IDLE.
- `div_clk_in`  in  1  divided clock under test; asynchronous.
- `n_meas`  out  8  last measured period in `clk` cycles.
- `high_meas`  out  8  last measured high time in `clk` cycles.
- `meas_valid`  out  1  one-cycle pulse when `n_meas`/`high_meas` update.
- `duty_ok`  out  1  `|2*high_meas - n_meas| <= 1` for the last measurement.
- `locked`  out  1  period stable for `LOCK_COUNT` measurements.
- `overflow`  out  1  no rising edge within 255 cycles; sticky until next `meas_valid`.

## Operation
- `div_clk_in` passes through a 2-FF synchronizer, then a 1-FF delayed copy; rise = sync & ~delayed, fall = ~sync & delayed.
- States: IDLE, ARM, MEASURE.
- IDLE: counters cleared, `locked`=0. `enable`=1 -> ARM.
- ARM: wait for rise; on rise, `per_cnt`<=1, `hi_cnt`<=1, -> MEASURE.
- MEASURE: each cycle without rise, `per_cnt`+=1; `hi_cnt`+=1 while synced level high and no fall seen since last rise.
- On rise in MEASURE: `n_meas`<=`per_cnt`, `high_meas`<=`hi_cnt`, `meas_valid` pulses, `overflow`<=0, counters restart at 1, stay in MEASURE.
- Saturation: if `per_cnt`==255 and no rise, `overflow`<=1, `locked`<=0, -> ARM. 8-bit counters never wrap.
- `duty_ok` computed on the values being latched (9-bit arithmetic), registered with `n_meas`.
- Minimum measurable period is 2; passthrough (divisor 0/1) is not measurable and ends in `overflow`.
- `enable` falling in any state -> IDLE next cycle; `n_meas`, `high_meas`, `duty_ok`, `overflow` hold their values.
- Rise coinciding with saturation: rise wins (measurement of 255 is valid).

## Timing
- Reset values: `n_meas`=0, `high_meas`=0, `meas_valid`=0, `duty_ok`=0, `locked`=0, `overflow`=0, state IDLE.
- Input-to-edge-detect latency: 3 `clk` cycles; constant, so it cancels out of period measurement.
- First `meas_valid`: one full input period after the first detected rise following `enable`.
- `meas_valid` high exactly one cycle per detected rise in MEASURE; never in IDLE/ARM.
- `locked` updates in the same cycle as `meas_valid`.
- Reset assertion mid-measurement: all outputs to reset values immediately (async); re-arm requires a fresh rise.

## Configuration
- `CLOCK_RATIO_METER_LOCK_EN` defined: lock counter (4 bits) compares each `n_meas` with the previous; equal -> increment (saturate at `LOCK_COUNT`), different -> reset to 1 and clear `locked`; `locked`=1 when count reaches `LOCK_COUNT`.
- Not defined: lock counter absent, `locked` tied to 0, `LOCK_COUNT` unused.

## Structure
- Package `clock_meter_pkg`: state enum (IDLE, ARM, MEASURE), `CNT_W`=8, `CNT_MAX`=255.
- One sub-module: `sync_edge_detect` (2-FF sync + delayed copy, outputs level, rise, fall); all else in `clock_ratio_meter`.

## Test plan
- Divider n=4 driven on `div_clk_in`, enable=1 -> `meas_valid` every 4 cycles, `n_meas`=4, `high_meas`=2, `duty_ok`=1.
- Divider n=7 -> `n_meas`=7, `high_meas` in {3,4}, `duty_ok`=1; with macro, `locked`=1 at 4th `meas_valid`.
- Locked at n=6, switch to n=10 -> first mismatched `meas_valid` reports 10, `locked`=0; re-locks after 4 periods of 10.
- Hold `div_clk_in` low after lock -> `overflow`=1 and `locked`=0 at the 255th cycle after last rise; restart -> `overflow`=0 at next `meas_valid`.
- Assert `reset_n`=0 mid-period -> all outputs 0 same cycle; release -> no `meas_valid` until ARM sees a rise plus one full period.
- Deassert `enable` mid-period -> IDLE, no further `meas_valid`, `n_meas` holds last value.
